// File: rtl/spike_dispatcher.sv
// Spike dispatcher: pops one event from the scheduler FIFO and sweeps every
// post-synaptic neuron with a req/ack update, reporting busy/done/count.
module spike_dispatcher #(
    parameter int N  = 256,
    parameter int M  = 10,
    parameter int NA = 8
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            SCHED_EMPTY,
    input  logic [M+1:0]    SCHED_DATA_OUT,
    output logic            CTRL_SCHED_POP_N,
    input  logic            SPI_GATE_ACTIVITY,
    output logic            DISP_NEUR_REQ,
    output logic [NA-1:0]   DISP_NEUR_ADDR,
    output logic [1:0]      DISP_NEUR_OP,
    output logic [M+NA-1:0] DISP_SYN_ADDR,
    input  logic            NEUR_DISP_ACK,
    output logic            DISP_BUSY,
    output logic            DISP_EVT_DONE,
    output logic [15:0]     DISP_EVT_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LEAK = 2'b11;

    state_t        state;
    state_t        state_next;
    logic          gate_meta;
    logic          gate_sync;
    logic [NA-1:0] idx;
    logic [1:0]    evt_virts;
    logic [M-1:0]  evt_addr;
    logic [M-1:0]  syn_pre;
    logic [15:0]   evt_cnt;
    logic          pop;
    logic          last_idx;

    assign last_idx = (idx == NA'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            gate_meta <= 1'b0;
            gate_sync <= 1'b0;
        end else begin
            gate_meta <= SPI_GATE_ACTIVITY;
            gate_sync <= gate_meta;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!SCHED_EMPTY && !gate_sync) begin
                    pop        = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (NEUR_DISP_ACK && last_idx) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The event word is only sampled on the pop edge; later FIFO refills are invisible.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            idx       <= '0;
            evt_virts <= 2'b00;
            evt_addr  <= '0;
        end else if (pop) begin
            idx       <= '0;
            evt_virts <= SCHED_DATA_OUT[M+1:M];
            evt_addr  <= SCHED_DATA_OUT[M-1:0];
        end else if (state == SWEEP && NEUR_DISP_ACK && !last_idx) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            evt_cnt <= 16'h0000;
        end else if (state == DONE && evt_cnt != 16'hFFFF) begin
            evt_cnt <= evt_cnt + 16'h0001;
        end
    end

    // Pop is masked by reset so the FIFO never loses a word while we are held in reset.
    assign CTRL_SCHED_POP_N = !(pop && RSTN);

    assign syn_pre        = (evt_virts == OP_LEAK) ? '0 : evt_addr;
    assign DISP_NEUR_REQ  = (state == SWEEP);
    assign DISP_NEUR_ADDR = idx;
    assign DISP_NEUR_OP   = evt_virts;
    assign DISP_SYN_ADDR  = {syn_pre, idx};
    assign DISP_BUSY      = (state != IDLE);
    assign DISP_EVT_DONE  = (state == DONE);
    assign DISP_EVT_CNT   = evt_cnt;

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Downstream consumer of the spike scheduler FIFO.
- Pops one 12-bit event {VIRTS[1:0], ADDR[M-1:0]} at a time and sweeps all N post-synaptic neurons.
- For each neuron, issues one req/ack update to the neuron core, with the synapse address and the operation code decoded from VIRTS.
- Reports busy, an end-of-event pulse and a processed-event counter to the controller.

Parameters:
- N, 256, number of post-synaptic neurons swept per event (power of two).
- M, 10, pre-synaptic address width; M+2 must equal the 12-bit scheduler word.
- NA, 8, post-neuron index width, equal to log2(N).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- SCHED_EMPTY  in  1  scheduler FIFO empty.
- SCHED_DATA_OUT  in  12  head-of-FIFO word {virts, addr}; valid whenever SCHED_EMPTY=0 (first-word-fall-through).
- CTRL_SCHED_POP_N  out  1  active-low pop to the scheduler.
- SPI_GATE_ACTIVITY  in  1  async config bit; 1 = stop accepting new events.
- DISP_NEUR_REQ  out  1  neuron update request.
- DISP_NEUR_ADDR  out  NA  post-neuron index.
- DISP_NEUR_OP  out  2  00 = synaptic integrate, 01 = virtual excite, 10 = virtual inhibit, 11 = leak/time-step.
- DISP_SYN_ADDR  out  M+NA  synapse memory address {pre_addr, post_idx}.
- NEUR_DISP_ACK  in  1  neuron core accepts the current request.
- DISP_BUSY  out  1  event in progress.
- DISP_EVT_DONE  out  1  one-cycle pulse at event completion.
- DISP_EVT_CNT  out  16  processed-event counter, saturating.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State = IDLE, CTRL_SCHED_POP_N=1, all other outputs 0.
  - Internal index and latched event cleared; gate synchronizer cleared.
  - Reset mid-sweep abandons the event; no DONE pulse and no count increment.
- SPI_GATE_ACTIVITY passes through a 2-FF synchronizer; only gate_sync is used.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - If SCHED_EMPTY=0 and gate_sync=0, drive CTRL_SCHED_POP_N=0 combinationally for exactly this cycle.
  - Latch SCHED_DATA_OUT into evt_virts/evt_addr at this edge; index <= 0; go to SWEEP.
  - Otherwise POP_N=1 and stay in IDLE.
  - POP_N is never low outside IDLE and never low while SCHED_EMPTY=1.
- SWEEP:
  - DISP_NEUR_REQ=1; DISP_NEUR_ADDR=index; DISP_NEUR_OP=evt_virts; DISP_SYN_ADDR={evt_addr, index}.
  - Outputs are registered from state/index, stable while REQ=1 and ACK=0.
  - ACK is sampled at the rising edge only while REQ=1; ACK when REQ=0 is ignored.
  - On ACK with index<N-1: index+1, REQ stays 1 (back-to-back, one neuron per cycle at best).
  - On ACK with index=N-1: go to DONE; REQ=0 next cycle.
  - For OP=11 (leak), evt_addr is forced to 0 on DISP_SYN_ADDR.
- DONE:
  - DISP_EVT_DONE=1 for one cycle; DISP_EVT_CNT increments, saturating at 16'hFFFF.
  - Go to IDLE; no pop in this cycle.
- DISP_BUSY=1 in SWEEP and DONE, 0 in IDLE.
- Latency: with ACK tied high, pop-to-pop = N+2 cycles (1 IDLE/pop + N SWEEP + 1 DONE).
- Gate asserted mid-sweep: the current event completes normally; no further pop while gate_sync=1.
- Gate is re-checked in every IDLE cycle.
- FIFO refill while in SWEEP/DONE is invisible; the head word is only sampled in IDLE.
- Index wrap: the index never passes N-1; the counter increment is guarded (no wrap to 0).

Test Plan:
- Reset, FIFO empty, ACK=1 for 20 cycles -> POP_N stays 1, REQ=0, BUSY=0, CNT=0.
- Push one event 12'h005 (virts=00, addr=5), ACK=1:
  - POP_N low for exactly 1 cycle.
  - REQ high 256 consecutive cycles with NEUR_ADDR 0..255 and SYN_ADDR 18'h00500..18'h005FF, OP=00.
  - One DONE pulse; CNT=1; total 258 cycles.
- Two queued events 12'h403 then 12'hC00, ACK=1:
  - First event sweeps with OP=01.
  - Second is popped the cycle after DONE, sweeps with OP=11, SYN_ADDR upper bits 0.
  - CNT=2; no pop during either sweep.
- ACK stalled (ACK=0 for 3 cycles at index 7): REQ, NEUR_ADDR=7 and SYN_ADDR held constant; index advances only on ACK; ACK pulsed while REQ=0 has no effect.
- Gate set mid-sweep with 3 events queued: current event finishes (DONE, CNT+1); POP_N stays 1 while gate=1; after clearing, the pop occurs 2-3 cycles later.
- RSTN low at index 100: all outputs 0 immediately, POP_N=1, CNT=0; after release the next queued event sweeps from index 0.
